uart_tx_feeder: RTL

//  Byte buffer and pacer directly upstream of uart_transmit: accepts bytes on a valid/ready port,

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_byte_fifo.sv | 74 +++++++
 rtl/uart_tx_feeder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit feeder.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } feeder_state_t;

  localparam int UART_CLK_HZ     = 5_000_000;
  localparam int UART_BAUD       = 9600;
  localparam int UART_FRAME_BITS = 10;

endpackage : uart_pkg

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with occupancy count; head byte is visible on rd_data whenever not empty.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  byte_t                    wr_data,
  input  logic                     pop,
  output byte_t                    rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  byte_t           mem_q [DEPTH];
  byte_t           mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            do_push;
  logic            do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and count; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Control registers take the synchronous reset; the data array does not need one.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage update.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule : uart_byte_fifo

// File: rtl/uart_tx_feeder.sv
// Queues bytes and launches them into uart_transmit one per frame, paced by a frame timer.
//
// state  | meaning
// IDLE   | nothing in flight; launch as soon as the FIFO holds a byte
// LAUNCH | dataReady high for this single cycle; frame timer loaded
// WAIT   | frame (plus guard bits) on the line; timer counts down to 0
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = UART_CLK_HZ,
  parameter int BAUD       = UART_BAUD,
  parameter int FRAME_BITS = UART_FRAME_BITS,
  parameter int GUARD_BITS = 1,
  parameter int DEPTH      = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic                     dataReady,
  output logic [7:0]               dataIn,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     overflow
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int FRAME_CLKS   = (FRAME_BITS + GUARD_BITS) * CLKS_PER_BIT;
  localparam int TW           = $clog2(FRAME_CLKS);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "uart_tx_feeder: DEPTH must be a power of 2 and at least 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $fatal(1, "uart_tx_feeder: CLK_HZ/BAUD must be at least 2");
  end

  feeder_state_t   state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            dataready_q, dataready_d;
  byte_t           data_in_q, data_in_d;
  logic            overflow_q, overflow_d;

  logic            fifo_push;
  logic            fifo_pop;
  byte_t           fifo_head;
  logic            fifo_full;
  logic            fifo_empty;

  // A write on the edge where the FIFO is full is dropped even if a pop happens on that edge.
  assign fifo_push = wr_valid && !fifo_full;
  assign wr_ready  = !fifo_full;
  assign dataReady = dataready_q;
  assign dataIn    = data_in_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sequencer: pop decisions use the registered FIFO state, so a byte written this edge waits one cycle.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    dataready_d = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d     = LAUNCH;
          fifo_pop    = 1'b1;
          dataready_d = 1'b1;
        end
      end
      LAUNCH: begin
        timer_d = TW'(FRAME_CLKS - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (timer_q == '0) begin
          if (!fifo_empty) begin
            state_d     = LAUNCH;
            fifo_pop    = 1'b1;
            dataready_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Launch byte is captured only on pop edges and the overflow flag is sticky.
  always_comb begin
    data_in_d  = fifo_pop ? fifo_head : data_in_q;
    overflow_d = overflow_q | (wr_valid & fifo_full);
  end

  // Feeder registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      dataready_q <= 1'b0;
      data_in_q   <= 8'h00;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      dataready_q <= dataready_d;
      data_in_q   <= data_in_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule : uart_tx_feeder
